bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the SoC memory bus, using the req_ready/read/write/address/data and res_valid/data protocol.
- Master 0 is the HTIF host bridge and master 1 is the core data port; the slave is the memory/IO bus.
- Round-robin arbitration with at most one outstanding read. Writes complete when the slave accepts them.
- A response timeout watchdog returns an error response so that no master hangs.

---
 rtl/bus_arbiter.sv | 177 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the SoC memory bus.
// Allows one outstanding read; a watchdog answers reads the slave never completes.
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic              m0_req_ready,
  input  logic              m0_req_read,
  input  logic              m0_req_write,
  input  logic [ADDR_W-1:0] m0_req_address,
  input  logic [DATA_W-1:0] m0_req_data,
  output logic              m0_res_valid,
  output logic [DATA_W-1:0] m0_res_data,
  output logic              m0_res_error,
  output logic              m1_req_ready,
  input  logic              m1_req_read,
  input  logic              m1_req_write,
  input  logic [ADDR_W-1:0] m1_req_address,
  input  logic [DATA_W-1:0] m1_req_data,
  output logic              m1_res_valid,
  output logic [DATA_W-1:0] m1_res_data,
  output logic              m1_res_error,
  input  logic              s_req_ready,
  output logic              s_req_read,
  output logic              s_req_write,
  output logic [ADDR_W-1:0] s_req_address,
  output logic [DATA_W-1:0] s_req_data,
  input  logic              s_res_valid,
  input  logic [DATA_W-1:0] s_res_data,
  output logic              busy,
  output logic [TO_W-1:0]   timeout_count
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              state_r;
  logic                prio_r;
  logic                owner_r;
  logic [CNT_W-1:0]    wait_cnt_r;
  logic [TO_W-1:0]     timeout_count_r;
  logic                m0_res_valid_r;
  logic [DATA_W-1:0]   m0_res_data_r;
  logic                m0_res_error_r;
  logic                m1_res_valid_r;
  logic [DATA_W-1:0]   m1_res_data_r;
  logic                m1_res_error_r;

  logic want0_s;
  logic want1_s;
  logic winner_s;
  logic active_s;
  logic win_read_s;
  logic win_write_s;
  logic handshake_s;

  // Winner selection and request routing; a read+write request counts as a read.
  always_comb begin
    want0_s = m0_req_read | m0_req_write;
    want1_s = m1_req_read | m1_req_write;
    if (want0_s && want1_s) begin
      winner_s = prio_r;
    end else if (want1_s) begin
      winner_s = 1'b1;
    end else begin
      winner_s = 1'b0;
    end
    active_s = (state_r == ST_IDLE) && (want0_s || want1_s);
    if (winner_s) begin
      win_read_s    = m1_req_read;
      win_write_s   = m1_req_write & ~m1_req_read;
      s_req_address = m1_req_address;
      s_req_data    = m1_req_data;
    end else begin
      win_read_s    = m0_req_read;
      win_write_s   = m0_req_write & ~m0_req_read;
      s_req_address = m0_req_address;
      s_req_data    = m0_req_data;
    end
    s_req_read   = active_s & win_read_s;
    s_req_write  = active_s & win_write_s;
    m0_req_ready = active_s & ~winner_s & s_req_ready;
    m1_req_ready = active_s & winner_s & s_req_ready;
    handshake_s  = active_s & s_req_ready;
  end

  // Arbitration state, wait watchdog and registered responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r         <= ST_IDLE;
      prio_r          <= 1'b0;
      owner_r         <= 1'b0;
      wait_cnt_r      <= '0;
      timeout_count_r <= '0;
      m0_res_valid_r  <= 1'b0;
      m0_res_data_r   <= '0;
      m0_res_error_r  <= 1'b0;
      m1_res_valid_r  <= 1'b0;
      m1_res_data_r   <= '0;
      m1_res_error_r  <= 1'b0;
    end else begin
      m0_res_valid_r <= 1'b0;
      m1_res_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (handshake_s) begin
            prio_r <= ~winner_s;
            if (win_read_s) begin
              owner_r    <= winner_s;
              wait_cnt_r <= '0;
              state_r    <= ST_WAIT;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          wait_cnt_r <= wait_cnt_r + CNT_W'(1);
          // A response arriving in the final watchdog cycle still wins.
          if (s_res_valid) begin
            if (owner_r) begin
              m1_res_valid_r <= 1'b1;
              m1_res_data_r  <= s_res_data;
              m1_res_error_r <= 1'b0;
            end else begin
              m0_res_valid_r <= 1'b1;
              m0_res_data_r  <= s_res_data;
              m0_res_error_r <= 1'b0;
            end
            state_r <= ST_IDLE;
          end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
            if (owner_r) begin
              m1_res_valid_r <= 1'b1;
              m1_res_data_r  <= '0;
              m1_res_error_r <= 1'b1;
            end else begin
              m0_res_valid_r <= 1'b1;
              m0_res_data_r  <= '0;
              m0_res_error_r <= 1'b1;
            end
            if (timeout_count_r != {TO_W{1'b1}}) begin
              timeout_count_r <= timeout_count_r + TO_W'(1);
            end else begin
              timeout_count_r <= timeout_count_r;
            end
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign m0_res_valid  = m0_res_valid_r;
  assign m0_res_data   = m0_res_data_r;
  assign m0_res_error  = m0_res_error_r;
  assign m1_res_valid  = m1_res_valid_r;
  assign m1_res_data   = m1_res_data_r;
  assign m1_res_error  = m1_res_error_r;
  assign busy          = (state_r == ST_WAIT);
  assign timeout_count = timeout_count_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios with literal expectations plus a
// per-cycle transaction-level model compared on every falling edge.
module tb_bus_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;
  localparam int TOW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req_ready, m0_req_read, m0_req_write;
  logic [AW-1:0] m0_req_address;
  logic [DW-1:0] m0_req_data;
  logic          m0_res_valid, m0_res_error;
  logic [DW-1:0] m0_res_data;
  logic          m1_req_ready, m1_req_read, m1_req_write;
  logic [AW-1:0] m1_req_address;
  logic [DW-1:0] m1_req_data;
  logic          m1_res_valid, m1_res_error;
  logic [DW-1:0] m1_res_data;
  logic          s_req_ready, s_req_read, s_req_write;
  logic [AW-1:0] s_req_address;
  logic [DW-1:0] s_req_data;
  logic          s_res_valid;
  logic [DW-1:0] s_res_data;
  logic          busy;
  logic [TOW-1:0] timeout_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .TO_W(TOW)) dut (
    .clock(clock), .reset(reset),
    .m0_req_ready(m0_req_ready), .m0_req_read(m0_req_read), .m0_req_write(m0_req_write),
    .m0_req_address(m0_req_address), .m0_req_data(m0_req_data),
    .m0_res_valid(m0_res_valid), .m0_res_data(m0_res_data), .m0_res_error(m0_res_error),
    .m1_req_ready(m1_req_ready), .m1_req_read(m1_req_read), .m1_req_write(m1_req_write),
    .m1_req_address(m1_req_address), .m1_req_data(m1_req_data),
    .m1_res_valid(m1_res_valid), .m1_res_data(m1_res_data), .m1_res_error(m1_res_error),
    .s_req_ready(s_req_ready), .s_req_read(s_req_read), .s_req_write(s_req_write),
    .s_req_address(s_req_address), .s_req_data(s_req_data),
    .s_res_valid(s_res_valid), .s_res_data(s_res_data),
    .busy(busy), .timeout_count(timeout_count)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Transaction-level model: is a read in flight, for whom, how long, who is favoured.
  bit            m_pend  = 1'b0;
  bit            m_owner = 1'b0;
  int            m_age   = 0;
  bit            m_fav   = 1'b0;
  bit   [1:0]    m_valid = 2'b00;
  logic [DW-1:0] m_data [2] = '{32'h0, 32'h0};
  bit            m_err  [2] = '{1'b0, 1'b0};
  int            m_tocnt = 0;
  bit            c_w0, c_w1, c_any, c_g, c_rd, c_wr;

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      m_pend = 1'b0; m_owner = 1'b0; m_age = 0; m_fav = 1'b0; m_valid = 2'b00;
      m_data[0] = '0; m_data[1] = '0; m_err[0] = 1'b0; m_err[1] = 1'b0; m_tocnt = 0;
    end
    c_w0  = m0_req_read | m0_req_write;
    c_w1  = m1_req_read | m1_req_write;
    c_any = !m_pend && (c_w0 || c_w1);
    c_g   = (c_w0 && c_w1) ? m_fav : c_w1;
    c_rd  = c_g ? m1_req_read : m0_req_read;
    c_wr  = c_g ? m1_req_write : m0_req_write;
    chk("model_s_req_read", s_req_read, c_any && c_rd);
    chk("model_s_req_write", s_req_write, c_any && !c_rd && c_wr);
    if (c_any) begin
      chk("model_s_req_address", s_req_address, c_g ? m1_req_address : m0_req_address);
      chk("model_s_req_data", s_req_data, c_g ? m1_req_data : m0_req_data);
    end
    chk("model_m0_req_ready", m0_req_ready, c_any && !c_g && s_req_ready);
    chk("model_m1_req_ready", m1_req_ready, c_any && c_g && s_req_ready);
    chk("model_busy", busy, m_pend);
    chk("model_m0_res_valid", m0_res_valid, m_valid[0]);
    chk("model_m1_res_valid", m1_res_valid, m_valid[1]);
    chk("model_m0_res_data", m0_res_data, m_data[0]);
    chk("model_m1_res_data", m1_res_data, m_data[1]);
    if (m_valid[0]) chk("model_m0_res_error", m0_res_error, m_err[0]);
    if (m_valid[1]) chk("model_m1_res_error", m1_res_error, m_err[1]);
    chk("model_timeout_count", timeout_count, m_tocnt);
    if (reset) begin
      m_valid = 2'b00;
      if (m_pend) begin
        if (s_res_valid) begin
          m_valid[m_owner] = 1'b1; m_data[m_owner] = s_res_data; m_err[m_owner] = 1'b0;
          m_pend = 1'b0;
        end else if (m_age == TMO - 1) begin
          m_valid[m_owner] = 1'b1; m_data[m_owner] = '0; m_err[m_owner] = 1'b1;
          if (m_tocnt < (1 << TOW) - 1) m_tocnt++;
          m_pend = 1'b0;
        end else begin
          m_age++;
        end
      end else if (c_any && s_req_ready) begin
        m_fav = !c_g;
        if (c_rd) begin
          m_pend = 1'b1; m_owner = c_g; m_age = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    m0_req_read = 1'b0; m0_req_write = 1'b0; m0_req_address = '0; m0_req_data = '0;
    m1_req_read = 1'b0; m1_req_write = 1'b0; m1_req_address = '0; m1_req_data = '0;
    s_req_ready = 1'b1; s_res_valid = 1'b0; s_res_data = '0;
    repeat (3) cyc();
    chk("rst_m0_res_valid", m0_res_valid, 1'b0);
    chk("rst_m0_res_data", m0_res_data, 32'h0);
    chk("rst_timeout_count", timeout_count, 2'd0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;

    // m0 read alone, response three cycles into the wait
    cyc(); m0_req_read = 1'b1; m0_req_address = 32'h100; #1;
    chk("t1_m0_ready", m0_req_ready, 1'b1);
    chk("t1_s_read", s_req_read, 1'b1);
    chk("t1_s_addr", s_req_address, 32'h100);
    chk("t1_m1_ready", m1_req_ready, 1'b0);
    cyc(); m0_req_read = 1'b0; #1;
    chk("t1_busy", busy, 1'b1);
    cyc(); cyc(); s_res_valid = 1'b1; s_res_data = 32'hCAFEF00D;
    cyc(); s_res_valid = 1'b0; #1;
    chk("t1_m0_res_valid", m0_res_valid, 1'b1);
    chk("t1_m0_res_data", m0_res_data, 32'hCAFEF00D);
    chk("t1_m0_res_error", m0_res_error, 1'b0);
    chk("t1_m1_res_valid", m1_res_valid, 1'b0);
    cyc(); #1;
    chk("t1_pulse_end", m0_res_valid, 1'b0);
    chk("t1_data_hold", m0_res_data, 32'hCAFEF00D);

    // continuous writes from both masters; m1 favoured after m0's read
    m0_req_write = 1'b1; m0_req_address = 32'h1000; m0_req_data = 32'hA0;
    m1_req_write = 1'b1; m1_req_address = 32'h2000; m1_req_data = 32'hB1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      #1;
      chk("t2_m1_ready", m1_req_ready, (i % 2 == 0));
      chk("t2_m0_ready", m0_req_ready, (i % 2 == 1));
      chk("t2_s_write", s_req_write, 1'b1);
      chk("t2_s_addr", s_req_address, (i % 2 == 0) ? 32'h2000 : 32'h1000);
      chk("t2_s_data", s_req_data, (i % 2 == 0) ? 32'hB1 : 32'hA0);
    end
    cyc(); m0_req_write = 1'b0; m1_req_write = 1'b0;

    // m1 read stalled by the slave for five cycles
    m1_req_read = 1'b1; m1_req_address = 32'h300; s_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_m1_ready_low", m1_req_ready, 1'b0);
      chk("t3_idle", busy, 1'b0);
      chk("t3_s_addr", s_req_address, 32'h300);
      cyc();
    end
    s_req_ready = 1'b1; #1;
    chk("t3_m1_ready_high", m1_req_ready, 1'b1);
    cyc(); m1_req_read = 1'b0; s_res_valid = 1'b1; s_res_data = 32'h12345678; #1;
    chk("t3_busy", busy, 1'b1);
    cyc(); s_res_valid = 1'b0; #1;
    chk("t3_m1_res_valid", m1_res_valid, 1'b1);
    chk("t3_m1_res_data", m1_res_data, 32'h12345678);
    chk("t3_m0_res_valid", m0_res_valid, 1'b0);

    // timeout with a silent slave, then a stray response
    cyc(); m1_req_read = 1'b1; m1_req_address = 32'h400; #1;
    chk("t4_m1_ready", m1_req_ready, 1'b1);
    cyc(); m1_req_read = 1'b0;
    repeat (7) cyc();
    chk("t4_still_busy", busy, 1'b1);
    chk("t4_no_early_valid", m1_res_valid, 1'b0);
    cyc();
    chk("t4_m1_res_valid", m1_res_valid, 1'b1);
    chk("t4_m1_res_error", m1_res_error, 1'b1);
    chk("t4_m1_res_data", m1_res_data, 32'h0);
    chk("t4_timeout_count", timeout_count, 2'd1);
    chk("t4_idle", busy, 1'b0);
    s_res_valid = 1'b1; s_res_data = 32'hDEAD;
    cyc(); s_res_valid = 1'b0; #1;
    chk("t4_stray_m1", m1_res_valid, 1'b0);
    chk("t4_stray_m0", m0_res_valid, 1'b0);
    chk("t4_stray_idle", busy, 1'b0);
    chk("t4_stray_data", m1_res_data, 32'h0);

    // reset during WAIT, then simultaneous reads grant m0 first
    cyc(); m0_req_read = 1'b1; m0_req_address = 32'h500;
    cyc(); m0_req_read = 1'b0; #1;
    chk("t5_busy", busy, 1'b1);
    cyc(); reset = 1'b0; #1;
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_m0_data", m0_res_data, 32'h0);
    chk("t5_rst_timeouts", timeout_count, 2'd0);
    repeat (2) cyc();
    reset = 1'b1;
    cyc(); m0_req_read = 1'b1; m0_req_address = 32'h600;
    m1_req_read = 1'b1; m1_req_address = 32'h700; #1;
    chk("t5_m0_first", m0_req_ready, 1'b1);
    chk("t5_m1_wait", m1_req_ready, 1'b0);
    chk("t5_s_addr", s_req_address, 32'h600);
    cyc(); m0_req_read = 1'b0; s_res_valid = 1'b1; s_res_data = 32'h06000600;
    cyc(); s_res_valid = 1'b0; #1;
    chk("t5_m0_res_valid", m0_res_valid, 1'b1);
    chk("t5_m0_res_data", m0_res_data, 32'h06000600);
    chk("t5_m1_granted", m1_req_ready, 1'b1);
    chk("t5_s_addr_m1", s_req_address, 32'h700);
    cyc(); m1_req_read = 1'b0; s_res_valid = 1'b1; s_res_data = 32'h07000700;
    cyc(); s_res_valid = 1'b0; #1;
    chk("t5_m1_res_valid", m1_res_valid, 1'b1);
    chk("t5_m1_res_data", m1_res_data, 32'h07000700);

    // read and write together is a read
    cyc(); m0_req_read = 1'b1; m0_req_write = 1'b1; m0_req_address = 32'h40; #1;
    chk("t6_s_read", s_req_read, 1'b1);
    chk("t6_s_write", s_req_write, 1'b0);
    chk("t6_s_addr", s_req_address, 32'h40);
    cyc(); m0_req_read = 1'b0; m0_req_write = 1'b0; s_res_valid = 1'b1; s_res_data = 32'h40404040;
    cyc(); s_res_valid = 1'b0; #1;
    chk("t6_m0_res_valid", m0_res_valid, 1'b1);
    chk("t6_m0_res_data", m0_res_data, 32'h40404040);

    // timeout counter saturates at all-ones
    for (int k = 1; k <= 4; k++) begin
      cyc(); m1_req_read = 1'b1; m1_req_address = 32'h800;
      cyc(); m1_req_read = 1'b0;
      repeat (8) cyc();
      chk("t7_error", m1_res_error, 1'b1);
      chk("t7_timeout_count", timeout_count, (k < 3) ? k : 3);
    end

    repeat (3) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
